seg_digit_scanner: RTL and testbench
====================================

// Module: seg_digit_scanner
// PURPOSE
//  Time-multiplexed scan driver for the 4-digit 7-segment display.
//  Sits directly upstream of the 2-to-4 enabled decoder: drives its A, B and E
//  inputs so exactly one anode slot is active at a time.
//  Also presents the 4-bit value for the active slot to the segment encoder.
//  Display contents are double-buffered and swapped only at frame boundaries (tear-free).
// PARAMETERS
//  PRESCALE  100000  clk cycles per digit slot (100 MHz -> 1 kHz slot rate); legal >= 2
//  PWM_BITS  3       brightness resolution; PWM period = 2**PWM_BITS clk cycles
// PORTS
//  clk         in   1            system clock, rising edge
//  rst_n       in   1            asynchronous active-low reset
//  digits_in   in   16           staged digits; [3:0]=slot0 ... [15:12]=slot3
//  blank_in    in   4            staged blank mask; bit i=1 forces slot i dark
//  bright_in   in   PWM_BITS     staged brightness; 0=off, N -> N/2**PWM_BITS duty
//  upd_req     in   1            update request (level); hold until upd_ack
//  upd_ack     out  1            1-cycle pulse: staged inputs captured
//  sel_a       out  1            decoder A = slot[1]
//  sel_b       out  1            decoder B = slot[0]
//  sel_en      out  1            decoder E; 1 = active slot lit
//  digit_val   out  4            digit value for current slot
//  frame_start out  1            1-cycle pulse when slot wraps 3->0
// BEHAVIOUR
//  Reset (async, rst_n=0): prescaler=0, slot=0, pwm_cnt=0; active regs:
//   digits=0, blank=4'hF, bright=0. Outputs: sel_a=sel_b=sel_en=0,
//   digit_val=0, upd_ack=0, frame_start=0. Display stays dark until first update.
//  Prescaler: counts 0..PRESCALE-1 and wraps; tick = (count==PRESCALE-1).
//  Slot: 2-bit counter, advances on tick; 3->0 wraps (wrap = tick && slot==3).
//  pwm_cnt: free-running PWM_BITS counter, +1 every clk, natural wrap.
//  Outputs are registered from the state of the previous cycle: after the edge on
//   which slot changes, sel_a/sel_b/digit_val show the new slot one clk later.
//  sel_en (registered) = !blank[slot] && (pwm_cnt < bright); bright=0 -> never lit.
//  frame_start registered: high for the one clk after the wrap edge.
//  Update handshake:
//   - Capture occurs only on the wrap edge, when upd_req=1 on that cycle.
//   - Values present on that cycle are captured; earlier values are ignored.
//   - digits, blank and bright are copied into the active regs atomically.
//   - upd_ack pulses 1 clk on the next cycle, coincident with frame_start.
//   - Requester deasserts upd_req after upd_ack.
//   - If upd_req is still high at the next wrap, a new capture and ack occur.
//   - upd_req=0 at wrap: no capture, no ack; active regs hold.
//  Async reset mid-frame: all state and outputs clear immediately, no clock needed.
//   A request outstanding at reset is dropped; requester must re-request.
//  No other interactions: brightness/blank changes only take effect via the handshake.
// TESTING (bench with PRESCALE=4, PWM_BITS=2)
//  1 rst_n=0 for 3 clk -> all outputs 0 during reset; after release, sel_en=0
//    for 2 full frames (32 clk); frame_start pulses every 16 clk.
//  2 digits_in=16'h3A5C, blank_in=0, bright_in=3, upd_req=1 mid-frame ->
//    no ack before wrap; upd_ack=1 exactly 1 clk after wrap edge.
//    Next frame: {sel_a,sel_b}=00,01,10,11 and digit_val=C,5,A,3, 4 clk each.
//  3 bright_in=1 via update -> sel_en high 1 of every 4 clk.
//    bright_in=0 -> sel_en never high.
//  4 blank_in=4'b0100, bright_in=3 -> sel_en=0 for all of slot 2;
//    slots 0,1,3 lit 3 of 4 clk.
//  5 upd_req held; digits_in changes 16'h1111->16'h2222 two clk before wrap ->
//    16'h2222 captured; with upd_req still held, ack repeats at following wrap.
//  6 rst_n pulsed low between clk edges mid-slot 2 -> outputs 0 without a clk edge;
//    active regs back to reset values; display dark until a new update.

Source files
------------

// File: rtl/seg_digit_scanner.sv
// Scan driver for a 4-digit 7-segment display: walks the anode decoder one slot at a time,
// applies PWM brightness and blanking, and swaps double-buffered contents only at frame wrap.
module seg_digit_scanner #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned PWM_BITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         digits_in,
    input  logic [3:0]          blank_in,
    input  logic [PWM_BITS-1:0] bright_in,
    input  logic                upd_req,
    output logic                upd_ack,
    output logic                sel_a,
    output logic                sel_b,
    output logic                sel_en,
    output logic [3:0]          digit_val,
    output logic                frame_start
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0]    presc_q;
    logic [1:0]          slot_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic [15:0]         act_digits_q;
    logic [3:0]          act_blank_q;
    logic [PWM_BITS-1:0] act_bright_q;

    logic       tick;
    logic       wrap;
    logic       lit;
    logic [3:0] slot_digit;

    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        wrap       = tick && (slot_q == 2'd3);
        slot_digit = act_digits_q[{slot_q, 2'b00} +: 4];
        lit        = !act_blank_q[slot_q] && (pwm_q < act_bright_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            slot_q  <= '0;
            pwm_q   <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + CNT_W'(1);
            if (tick) begin
                slot_q <= slot_q + 2'd1;
            end
            pwm_q <= pwm_q + PWM_BITS'(1);
        end
    end

    // Staged inputs land in the active set only on the frame wrap, so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_digits_q <= '0;
            act_blank_q  <= 4'hF;
            act_bright_q <= '0;
        end else if (wrap && upd_req) begin
            act_digits_q <= digits_in;
            act_blank_q  <= blank_in;
            act_bright_q <= bright_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a       <= 1'b0;
            sel_b       <= 1'b0;
            sel_en      <= 1'b0;
            digit_val   <= '0;
            frame_start <= 1'b0;
            upd_ack     <= 1'b0;
        end else begin
            sel_a       <= slot_q[1];
            sel_b       <= slot_q[0];
            sel_en      <= lit;
            digit_val   <= slot_digit;
            frame_start <= wrap;
            upd_ack     <= wrap && upd_req;
        end
    end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Scoreboard bench for seg_digit_scanner: a cycle-indexed reference model queues the expected
// outputs for each edge and a negedge monitor pops and compares them.
module tb_seg_digit_scanner;

    localparam int P     = 4;
    localparam int B     = 2;
    localparam int FRAME = 4 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  blank_in = '0;
    logic [B-1:0] bright_in = '0;
    logic        upd_req = 1'b0;
    logic        upd_ack, sel_a, sel_b, sel_en, frame_start;
    logic [3:0]  digit_val;

    seg_digit_scanner #(.PRESCALE(P), .PWM_BITS(B)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .blank_in(blank_in),
        .bright_in(bright_in), .upd_req(upd_req), .upd_ack(upd_ack), .sel_a(sel_a),
        .sel_b(sel_b), .sel_en(sel_en), .digit_val(digit_val), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       en;
        logic [3:0] d;
        logic       fs;
        logic       ack;
    } out_t;

    out_t        expq[$];
    int          checks = 0;
    int          passes = 0;
    int unsigned k = 0;   // clock edges since reset release
    logic [15:0] m_digits = '0;
    logic [3:0]  m_blank = 4'hF;
    logic [B-1:0] m_bright = '0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.a = sel_a; o.b = sel_b; o.en = sel_en; o.d = digit_val;
        o.fs = frame_start; o.ack = upd_ack;
        return o;
    endfunction

    // Reference model: position in the frame follows directly from the edge count.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            k = 0; m_digits = '0; m_blank = 4'hF; m_bright = '0;
            expq.delete();
        end else begin
            int   slot, pwm;
            bit   wrap;
            out_t e;
            slot  = (k / P) % 4;
            pwm   = k % (1 << B);
            wrap  = (k % FRAME) == FRAME - 1;
            e.a   = (slot / 2) == 1;
            e.b   = (slot % 2) == 1;
            e.d   = 4'((m_digits >> (4 * slot)) & 16'hF);
            e.en  = !m_blank[slot] && (pwm < int'(m_bright));
            e.fs  = wrap;
            e.ack = wrap && upd_req;
            if (e.ack) begin
                m_digits = digits_in; m_blank = blank_in; m_bright = bright_in;
            end
            expq.push_back(e);
            k++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n || expq.size() == 0) check("outputs_idle", 32'(dut_out()), 32'(out_t'(0)));
        else check("outputs", 32'(dut_out()), 32'(expq.pop_front()));
    end

    task automatic wait_phase(int ph);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (int'(k % FRAME) == ph) return;
            @(posedge clk); #1;
        end
        check("phase_timeout", 0, 1);
    endtask

    task automatic wait_ack(string name);
        bit got = 0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            @(negedge clk);
            if (upd_ack) begin got = 1; break; end
        end
        check(name, 32'(got), 1);
    endtask

    task automatic do_update(logic [15:0] d, logic [3:0] bl, logic [B-1:0] br);
        digits_in = d; blank_in = bl; bright_in = br; upd_req = 1'b1;
        wait_ack("upd_ack_seen");
        @(posedge clk); #1;
        upd_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (34) @(posedge clk);
        #1;
        // Request mid-frame; model expects ack only on the wrap.
        wait_phase(6);
        do_update(16'h3A5C, 4'h0, 2'd3);
        repeat (20) @(posedge clk);
        #1;
        do_update(16'h3A5C, 4'h0, 2'd1);
        repeat (20) @(posedge clk);
        #1;
        do_update(16'h3A5C, 4'h0, 2'd0);
        repeat (20) @(posedge clk);
        #1;
        do_update(16'h1234, 4'b0100, 2'd3);
        repeat (20) @(posedge clk);
        #1;
        // Held request: late data change is what gets captured, ack repeats next wrap.
        digits_in = 16'h1111; blank_in = 4'h0; bright_in = 2'd3; upd_req = 1'b1;
        wait_phase(14);
        digits_in = 16'h2222;
        wait_ack("held_ack_1");
        wait_ack("held_ack_2");
        @(posedge clk); #1;
        upd_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        // Async reset between edges while slot 2 is showing.
        upd_req = 1'b1;
        wait_phase(10);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(dut_out()), 32'(out_t'(0)));
        upd_req = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            digits_in = 16'($urandom);
            blank_in  = 4'($urandom_range(0, 15));
            bright_in = B'($urandom_range(0, 3));
            if (upd_ack) upd_req = 1'b0;
            else if (!upd_req && $urandom_range(0, 7) == 0) upd_req = 1'b1;
            @(posedge clk); #1;
        end
        upd_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
